// File: rtl/fp_mac_seq.sv
// fp_mac_seq: sequential bfloat16-style multiply-accumulate with a bias-seeded accumulator.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, len_i, bias_i   launch a run of len_i operand pairs, accumulator seeded with bias_i
//   op_valid_i, op_ready_o   operand pair handshake (ready only in ACCUM)
//   op_a_i, op_b_i           operand pair
//   res_valid_o, res_ready_i result handshake (valid only in OUT)
//   result_o                 accumulated result
//   busy_o                   high whenever the FSM is not IDLE
// Optional build macro FP_MAC_RELU_EN clamps negative results (including -0) to 16'h0000.
module fp_mac_seq #(
  parameter int LenW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [LenW-1:0] len_i,
  input  logic [15:0]     bias_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [15:0]     op_a_i,
  input  logic [15:0]     op_b_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [15:0]     result_o,
  output logic            busy_o
);
  typedef struct packed {
    logic       sgn;
    logic [7:0] exp;
    logic [6:0] man;
  } fp_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  // Subnormals flush to zero, overflow saturates to infinity, mantissas truncate.
  function automatic fp_t fp_mul(fp_t a, fp_t b);
    logic [15:0]       p;
    logic signed [9:0] e;
    fp_t               r;
    p     = {8'b0, 1'b1, a.man} * {8'b0, 1'b1, b.man};
    e     = $signed({2'b0, a.exp}) + $signed({2'b0, b.exp}) - 10'sd127 + (p[15] ? 10'sd1 : 10'sd0);
    r.sgn = a.sgn ^ b.sgn;
    r.exp = e[7:0];
    r.man = p[15] ? p[14:8] : p[13:7];
    if (a.exp == 8'h00 || b.exp == 8'h00 || e <= 10'sd0) begin
      r.exp = 8'h00;
      r.man = 7'h00;
    end else if (a.exp == 8'hff || b.exp == 8'hff || e >= 10'sd255) begin
      r.exp = 8'hff;
      r.man = 7'h00;
    end
    return r;
  endfunction

  // Magnitude-ordered add with three guard bits; exact cancellation gives +0.
  function automatic fp_t fp_add(fp_t a, fp_t b);
    fp_t               big;
    fp_t               sml;
    fp_t               r;
    logic [10:0]       mb;
    logic [10:0]       ms;
    logic [11:0]       s;
    logic [7:0]        d;
    logic signed [9:0] e;
    if (a.exp == 8'h00) return b;
    if (b.exp == 8'h00) return a;
    {big, sml} = ({a.exp, a.man} >= {b.exp, b.man}) ? {a, b} : {b, a};
    d  = big.exp - sml.exp;
    mb = {1'b1, big.man, 3'b000};
    ms = (d > 8'd10) ? 11'd0 : ({1'b1, sml.man, 3'b000} >> d);
    s  = (big.sgn == sml.sgn) ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
    e  = $signed({2'b0, big.exp});
    if (s[11]) begin
      s = s >> 1;
      e = e + 10'sd1;
    end
    for (int i = 0; i < 11; i++) begin
      if (!s[10] && s != 12'd0) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    r.sgn = big.sgn;
    r.exp = e[7:0];
    r.man = s[9:3];
    if (s == 12'd0 || e <= 10'sd0) r = '0;
    else if (e >= 10'sd255 || big.exp == 8'hff) r = {big.sgn, 8'hff, 7'h00};
    return r;
  endfunction

  state_t          state_q;
  state_t          state_d;
  fp_t             acc_q;
  fp_t             prod_q;
  logic            prod_valid_q;
  logic [LenW-1:0] cnt_q;
  logic            accept;
  logic            launch;

  assign accept      = (state_q == ACCUM) && op_valid_i;
  assign launch      = (state_q == IDLE) && start_i;
  assign op_ready_o  = state_q == ACCUM;
  assign res_valid_o = state_q == OUT;
  assign busy_o      = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? ((len_i != '0) ? ACCUM : DRAIN) : IDLE;
      ACCUM:   state_d = (accept && cnt_q == LenW'(1)) ? DRAIN : ACCUM;
      DRAIN:   state_d = OUT;
      OUT:     state_d = res_ready_i ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end

  // The product registered on an accept is folded one cycle later, so DRAIN absorbs the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prod_valid_q <= accept;
      if (accept) begin
        prod_q <= fp_mul(op_a_i, op_b_i);
        cnt_q  <= cnt_q - LenW'(1);
      end
      if (launch) begin
        acc_q <= bias_i;
        cnt_q <= len_i;
      end else if (prod_valid_q) begin
        acc_q <= fp_add(acc_q, prod_q);
      end
    end
  end

`ifdef FP_MAC_RELU_EN
  assign result_o = acc_q.sgn ? 16'h0000 : acc_q;
`else
  assign result_o = acc_q;
`endif

endmodule

// File: tb/tb_fp_mac_seq.sv
// tb_fp_mac_seq: directed scoreboard bench for fp_mac_seq.
module tb_fp_mac_seq;
  localparam int LenW = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [LenW-1:0] len_i = '0;
  logic [15:0]     bias_i = '0;
  logic            op_valid_i = 1'b0;
  logic            op_ready_o;
  logic [15:0]     op_a_i = '0;
  logic [15:0]     op_b_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [15:0]     result_o;
  logic            busy_o;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] held;
  logic [15:0] neg_bias_res;

  fp_mac_seq #(.LenW(LenW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i), .bias_i(bias_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", result_o);
      end else begin
        chk("result", result_o, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input int n, input logic [15:0] b, input bit push, input logic [15:0] r);
    if (push) exp_q.push_back(r);
    len_i   = LenW'(n);
    bias_i  = b;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("busy_after_start", {15'b0, busy_o}, 16'd1);
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b, input int gap);
    repeat (gap) begin
      chk("ready_in_gap", {15'b0, op_ready_o}, 16'd1);
      step();
    end
    op_a_i     = a;
    op_b_i     = b;
    op_valid_i = 1'b1;
    chk("op_ready", {15'b0, op_ready_o}, 16'd1);
    step();
    op_valid_i = 1'b0;
  endtask

  task automatic wait_res();
    int n = 1;
    while (!res_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("latency", 16'(n), 16'd2);
  endtask

  task automatic release_res();
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    chk("idle_after_handshake", {15'b0, busy_o}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FP_MAC_RELU_EN
    neg_bias_res = 16'h0000;
`else
    neg_bias_res = 16'hC040;
`endif
    #12;
    chk("rst_op_ready", {15'b0, op_ready_o}, 16'd0);
    chk("rst_res_valid", {15'b0, res_valid_o}, 16'd0);
    chk("rst_busy", {15'b0, busy_o}, 16'd0);
    chk("rst_result", result_o, 16'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // 1.0 * 2.0 with zero bias
    start_run(1, 16'h0000, 1'b1, 16'h4000);
    feed(16'h3F80, 16'h4000, 0);
    chk("drain_not_ready", {15'b0, op_ready_o}, 16'd0);
    wait_res();
    release_res();
    step();

    // 1 + 2 + 2 + 2 = 7.0, back-to-back operands
    start_run(3, 16'h3F80, 1'b1, 16'h40E0);
    for (int i = 0; i < 3; i++) feed(16'h3F80, 16'h4000, 0);
    chk("ready_drop_after_last", {15'b0, op_ready_o}, 16'd0);
    wait_res();
    release_res();
    step();

    // empty vector returns the bias (-3.0)
    start_run(0, 16'hC040, 1'b1, neg_bias_res);
    wait_res();
    chk("len0_result_direct", result_o, neg_bias_res);
    release_res();
    step();

    // 4 + 4 = 8.0 with a four-cycle gap
    start_run(2, 16'h0000, 1'b1, 16'h4100);
    feed(16'h4000, 16'h4000, 0);
    feed(16'h4000, 16'h4000, 4);
    wait_res();
    release_res();
    step();

    // result held in OUT while start and operands are pulsed
    start_run(1, 16'h0000, 1'b1, 16'h4000);
    feed(16'h4000, 16'h3F80, 0);
    wait_res();
    held = result_o;
    chk("held_value", held, 16'h4000);
    repeat (5) begin
      start_i    = 1'b1;
      op_valid_i = 1'b1;
      len_i      = LenW'(1);
      step();
      chk("hold_valid", {15'b0, res_valid_o}, 16'd1);
      chk("hold_result", result_o, held);
      chk("hold_not_ready", {15'b0, op_ready_o}, 16'd0);
    end
    start_i    = 1'b0;
    op_valid_i = 1'b0;
    release_res();

    // start in the first IDLE cycle, then reset mid-run
    start_run(3, 16'h0000, 1'b0, 16'h0000);
    feed(16'h3F80, 16'h4000, 0);
    feed(16'h3F80, 16'h4000, 0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_op_ready", {15'b0, op_ready_o}, 16'd0);
    chk("midrst_res_valid", {15'b0, res_valid_o}, 16'd0);
    chk("midrst_busy", {15'b0, busy_o}, 16'd0);
    chk("midrst_result", result_o, 16'h0000);
    step();
    rst_ni = 1'b1;
    step();
    start_run(1, 16'h0000, 1'b1, 16'h3F80);
    feed(16'h3F80, 16'h3F80, 0);
    wait_res();
    release_res();

    repeat (3) step();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mac_seq.md
# fp_mac_seq

Sequential floating-point multiply-accumulate stage for the tiny-nn datapath. It consumes a stream of fp_t operand pairs over a valid/ready handshake and multiplies each pair with the existing combinational fp_mul. It folds the products into a bias-initialised accumulator with the existing fp_add, then presents one fp_t neuron result downstream. It sits directly downstream of the operand source and feeds the activation/output stage. fp_t is the 16-bit tiny_nn_pkg type: 1 sign bit, 8 exponent bits, 7 mantissa bits.

## Interface
- LenW, default 8: width of the length field. Maximum vector length is 2^LenW-1.
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  begin a new accumulation. Sampled only in IDLE.
- len_i  input  LenW  number of operand pairs to accumulate. Sampled with start_i.
- bias_i  input  fp_t  initial accumulator value. Sampled with start_i.
- op_valid_i  input  1  operand pair valid.
- op_ready_o  output  1  operand pair accepted when op_valid_i and op_ready_o are both high.
- op_a_i, op_b_i  input  fp_t each  operand pair.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  downstream accepts the result.
- result_o  output  fp_t  accumulated result.
- busy_o  output  1  high in any state other than IDLE.

## Operation
- Registered FSM with four states: IDLE, ACCUM, DRAIN, OUT.
- IDLE, on start_i:
  - acc_q <= bias_i; cnt_q <= len_i.
  - Go to ACCUM if len_i != 0, otherwise go to DRAIN.
- ACCUM:
  - op_ready_o = 1.
  - On each accept: prod_q <= fp_mul(op_a_i, op_b_i), prod_valid_q <= 1, cnt_q decrements.
  - Accept with cnt_q == 1 -> DRAIN.
  - No accept in a cycle -> prod_valid_q <= 0. Gaps in op_valid_i are permitted.
- Every cycle with prod_valid_q high: acc_q <= fp_add(acc_q, prod_q).
- DRAIN: lasts exactly one cycle, in which the final product is folded in. Then go to OUT.
- OUT:
  - res_valid_o = 1 and result_o = acc_q. Both are held stable until res_ready_i.
  - Handshake -> IDLE.
- The result must equal the in-order fold bias + p0 + p1 + ... + p(n-1), using fp_mul/fp_add semantics unchanged. No extra rounding or reordering.
- start_i is ignored outside IDLE. The operand interface is not ready outside ACCUM.
- op_valid_i outside ACCUM is ignored, with no side effects.

## Timing
- Reset values:
  - state IDLE.
  - op_ready_o, res_valid_o and busy_o = 0.
  - result_o = 16'h0000; acc_q, prod_q, cnt_q and prod_valid_q = 0.
- Operand throughput: one pair per cycle when back-to-back.
- Latency: if the last pair is accepted in cycle t, res_valid_o is high in cycle t+2.
- len_i = 0: start_i in cycle t gives res_valid_o in cycle t+2 with result_o = bias_i.
- res_valid_o high with res_ready_i high in the same cycle: IDLE in the next cycle. A start_i in that next cycle is accepted.
- A minimum of one IDLE cycle separates consecutive results.
- Reset asserted mid-operation: all state returns to reset values immediately. A partial accumulation is discarded and no result is produced.

## Configuration
- FP_MAC_RELU_EN defined:
  - result_o = 16'h0000 whenever acc_q.sgn = 1. This covers negative values and -0.
  - Otherwise result_o = acc_q.
- FP_MAC_RELU_EN undefined: result_o = acc_q unmodified.
- Latency is identical in both builds.

## Test plan
- len=1, bias 0x0000, a=0x3F80, b=0x4000 -> result_o 0x4000, res_valid_o exactly 2 cycles after the accept.
- len=3, bias 0x3F80, three back-to-back pairs (0x3F80, 0x4000) -> op_ready_o high for 3 cycles, then result_o 0x40E0 (7.0).
- len=0, bias 0xC040 -> result_o 0xC040 two cycles after start. With FP_MAC_RELU_EN, result_o is 0x0000.
- len=2 with a 4-cycle op_valid_i gap between the pairs (0x4000, 0x4000) twice, bias 0 -> result_o 0x4100 (8.0). No accumulation during the gap.
- In OUT, hold res_ready_i low for 5 cycles while pulsing start_i and op_valid_i -> result_o and res_valid_o stable, op_ready_o = 0, start ignored. Release -> IDLE next cycle.
- len=3, reset asserted after the 2nd accept -> all outputs at reset values. A new len=1 run (0x3F80 × 0x3F80, bias 0) then gives 0x3F80.
